song_sequencer: RTL and testbench

//   Auto-play controller for the piano's Buzzer. Walks a song ROM entry by

---
 rtl/song_sequencer.sv | 141 ++++++++++++++
 tb/tb_song_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Auto-play sequencer: walks a synchronous song ROM and drives note/octave codes
// to the Buzzer with per-note duration, inter-note silence, pause and stop.
module song_sequencer #(
   parameter int unsigned TICKS_PER_UNIT = 12_500_000,
   parameter int unsigned GAP_TICKS      = 1_000_000,
   parameter int unsigned NUM_SONGS      = 4,
   parameter int unsigned SONG_LEN       = 64,
   localparam int unsigned SW = $clog2(NUM_SONGS),
   localparam int unsigned PW = $clog2(SONG_LEN),
   localparam int unsigned AW = SW + PW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic          pause,
   input  logic          song_next,
   input  logic          song_prev,
   output logic [AW-1:0] rom_addr,
   input  logic [10:0]   rom_data,
   output logic [3:0]    note_out,
   output logic [1:0]    octave_out,
   output logic [SW-1:0] song_idx,
   output logic          busy,
   output logic          done
);

   localparam int unsigned TW = $clog2(15 * TICKS_PER_UNIT + 1);
   typedef logic [TW-1:0] timer_t;
   localparam timer_t        TPU       = timer_t'(TICKS_PER_UNIT);
   localparam timer_t        GAP       = timer_t'(GAP_TICKS);
   localparam logic [PW-1:0] LAST_STEP = PW'(SONG_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] step_q, step_d;
   logic [SW-1:0] song_q, song_d;
   timer_t        timer_q, timer_d;
   logic [3:0]    note_q, note_d;
   logic [1:0]    oct_q, oct_d;
   logic [AW-1:0] rom_addr_q;
   logic [3:0]    dur_eff;

   // A zero duration plays as one unit.
   assign dur_eff = (rom_data[9:6] == 4'd0) ? 4'd1 : rom_data[9:6];

   // NOTE: every variable gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      song_d  = song_q;
      timer_d = timer_q;
      note_d  = note_q;
      oct_d   = oct_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               step_d  = '0;
               state_d = S_FETCH;
            end else if (song_next ^ song_prev) begin
               song_d = song_next ? song_q + SW'(1) : song_q - SW'(1);
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            note_d = rom_data[3:0];
            oct_d  = rom_data[5:4];
            if (rom_data[10]) begin
               state_d = S_DONE;
            end else begin
               timer_d = timer_t'(dur_eff) * TPU - GAP;
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            if (!pause) begin
               if (timer_q == timer_t'(1)) begin
                  timer_d = GAP;
                  state_d = S_GAP;
               end else begin
                  timer_d = timer_q - timer_t'(1);
               end
            end
         end
         S_GAP: begin
            if (!pause) begin
               if (timer_q == timer_t'(1)) begin
                  if (step_q == LAST_STEP) begin
                     state_d = S_DONE;
                  end else begin
                     step_d  = step_q + PW'(1);
                     state_d = S_FETCH;
                  end
               end else begin
                  timer_d = timer_q - timer_t'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (stop && state_q != S_IDLE) state_d = S_IDLE;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         song_q     <= '0;
         timer_q    <= '0;
         note_q     <= '0;
         oct_q      <= '0;
         rom_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         song_q     <= song_d;
         timer_q    <= timer_d;
         note_q     <= note_d;
         oct_q      <= oct_d;
         rom_addr_q <= {song_d, step_d};
      end
   end

   assign rom_addr   = rom_addr_q;
   assign note_out   = (state_q == S_PLAY && !pause) ? note_q : 4'd0;
   assign octave_out = oct_q;
   assign song_idx   = song_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a timeline model of each song checked every cycle,
// plus hand-computed latencies and on-times for the directed scenarios.
module tb_song_sequencer;

   localparam int T  = 10;
   localparam int G  = 2;
   localparam int NS = 4;
   localparam int SL = 4;

   logic        clk, rst_n, start, stop, pause, song_next, song_prev;
   logic [3:0]  rom_addr;
   logic [10:0] rom_data;
   logic [3:0]  note_out;
   logic [1:0]  octave_out;
   logic [1:0]  song_idx;
   logic        busy, done;

   logic [10:0] rom [0:NS*SL-1];

   int checks = 0;
   int errors = 0;
   int n_done, on_cnt, done_seen;

   song_sequencer #(
      .TICKS_PER_UNIT(T),
      .GAP_TICKS     (G),
      .NUM_SONGS     (NS),
      .SONG_LEN      (SL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .song_next (song_next),
      .song_prev (song_prev),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .note_out  (note_out),
      .octave_out(octave_out),
      .song_idx  (song_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected output timeline: one entry per cycle of an unpaused playback.
   typedef struct {
      logic [3:0] note;
      logic [1:0] oct;
      bit         pausable;
      bit         is_done;
   } ent_t;

   ent_t       q[$];
   logic [1:0] m_song;
   bit         model_en;
   ent_t       h;
   bit         have;
   logic [3:0] exp_note;

   function automatic void push(input logic [3:0] n, input logic [1:0] o, input bit p, input bit d);
      ent_t e;
      e.note = n; e.oct = o; e.pausable = p; e.is_done = d;
      q.push_back(e);
   endfunction

   function automatic void build(input logic [1:0] s);
      for (int st = 0; st < SL; st++) begin
         logic [10:0] e;
         int dur;
         e = rom[s*SL + st];
         push(4'd0, 2'd0, 1'b0, 1'b0);
         push(4'd0, 2'd0, 1'b0, 1'b0);
         if (e[10]) begin
            push(4'd0, 2'd0, 1'b0, 1'b1);
            return;
         end
         dur = (e[9:6] == 0) ? 1 : int'(e[9:6]);
         for (int i = 0; i < dur*T - G; i++) push(e[3:0], e[5:4], 1'b1, 1'b0);
         for (int i = 0; i < G; i++) push(4'd0, e[5:4], 1'b1, 1'b0);
         if (st == SL-1) push(4'd0, 2'd0, 1'b0, 1'b1);
      end
   endfunction

   always @(negedge clk) begin
      if (model_en) begin
         have = (q.size() > 0);
         if (have) h = q[0];
         exp_note = (have && !(h.pausable && pause)) ? h.note : 4'd0;
         check("note_out", note_out, exp_note);
         check("busy", busy, have);
         check("done", done, have && h.is_done);
         check("song_idx", song_idx, m_song);
         if (exp_note != 0) check("octave_out", octave_out, h.oct);
         if (have && stop) q.delete();
         else if (have) begin
            if (!(h.pausable && pause)) void'(q.pop_front());
         end else if (start && !stop) build(m_song);
         else if (song_next ^ song_prev) m_song = song_next ? m_song + 2'd1 : m_song - 2'd1;
      end
   end

   task automatic drive(input logic s, input logic p, input logic n, input logic v);
      @(posedge clk); #1;
      start = s; stop = p; song_next = n; song_prev = v;
      @(posedge clk); #1;
      start = 0; stop = 0; song_next = 0; song_prev = 0;
   endtask

   task automatic wait_done(input int budget, input logic [3:0] watch, output int nd, output int on);
      nd = -1;
      on = 0;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (note_out == watch) on++;
         if (done) begin
            nd = n;
            break;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NS*SL; i++) rom[i] = 11'h400;
      rom[0] = {1'b0, 4'd2, 2'd1, 4'd3};
      rom[1] = {1'b0, 4'd1, 2'd2, 4'd5};
      rom[2] = {1'b1, 4'd0, 2'd0, 4'd0};
      rom[4] = {1'b0, 4'd0, 2'd3, 4'd1};
      rom[5] = {1'b0, 4'd0, 2'd0, 4'd2};
      rom[6] = {1'b0, 4'd0, 2'd1, 4'd4};
      rom[7] = {1'b0, 4'd0, 2'd2, 4'd6};
      clk = 0; rst_n = 0; start = 0; stop = 0; pause = 0; song_next = 0; song_prev = 0;
      model_en = 0; m_song = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_note", note_out, 0);
      check("rst_oct", octave_out, 0);
      check("rst_song", song_idx, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1 rst_n = 1; model_en = 1;
      repeat (5) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_note", note_out, 0);
      check("idle_addr", rom_addr, 0);

      // Song selection in IDLE
      drive(0, 0, 0, 1);
      @(negedge clk);
      check("prev_wrap", song_idx, 3);
      check("prev_addr", rom_addr, 12);
      drive(0, 0, 1, 0);
      @(negedge clk);
      check("next_wrap", song_idx, 0);
      drive(0, 0, 1, 1);
      @(negedge clk);
      check("both_ignored", song_idx, 0);

      // Song 0 plain playback
      drive(1, 0, 0, 0);
      wait_done(200, 4'd3, n_done, on_cnt);
      check("song0_done_lat", n_done, 37);
      check("song0_note3_on", on_cnt, 18);
      @(negedge clk);
      check("song0_idle_busy", busy, 0);

      // song_next while busy is ignored
      drive(1, 0, 0, 0);
      drive(0, 0, 1, 0);
      @(negedge clk);
      check("next_busy", song_idx, 0);
      drive(0, 1, 0, 0);
      @(negedge clk);
      check("stop_busy", busy, 0);

      // Pause 5 cycles inside the first note
      drive(1, 0, 0, 0);
      fork
         wait_done(200, 4'd3, n_done, on_cnt);
         begin
            repeat (8) @(posedge clk);
            #1 pause = 1;
            repeat (5) @(posedge clk);
            #1 pause = 0;
         end
      join
      check("pause_done_lat", n_done, 42);
      check("pause_note3_on", on_cnt, 18);

      // Stop mid-PLAY, then start+stop together
      drive(1, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1 stop = 1;
      @(posedge clk);
      #1 stop = 0;
      @(negedge clk);
      check("stop_busy", busy, 0);
      check("stop_note", note_out, 0);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("stop_no_done", done_seen, 0);
      drive(1, 1, 0, 0);
      @(negedge clk);
      check("start_stop_idle", busy, 0);

      // Song 1: zero durations, no end flag, last step ends it
      drive(0, 0, 1, 0);
      @(negedge clk);
      check("select_song1", song_idx, 1);
      drive(1, 0, 0, 0);
      wait_done(200, 4'd1, n_done, on_cnt);
      check("song1_done_lat", n_done, 49);
      check("song1_note1_on", on_cnt, 8);

      // Asynchronous reset mid-PLAY
      drive(1, 0, 0, 0);
      repeat (15) @(posedge clk);
      #3;
      check("pre_rst_note", note_out, 2);
      model_en = 0;
      rst_n = 0;
      #1;
      check("async_note", note_out, 0);
      check("async_busy", busy, 0);
      check("async_song", song_idx, 0);
      check("async_addr", rom_addr, 0);
      check("async_oct", octave_out, 0);
      @(posedge clk);
      #1 rst_n = 1;
      q.delete();
      m_song = 0;
      model_en = 1;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
